// File: rtl/map_fla_seq.sv
// JEDEC-style flash command sequencer: decodes unlock/program/erase write sequences
// seen on the CPU bus and issues timed program strobes and erase requests.
module map_fla_seq #(
    parameter int unsigned WE_CYCLES    = 4,
    parameter int unsigned PROG_CYCLES  = 64,
    parameter int unsigned ERASE_CYCLES = 4096,
    parameter int unsigned CNT_W        = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fla_en,
    input  logic        m2,
    input  logic        cpu_rw,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dat,
    input  logic [7:0]  prg_bank,
    output logic        fla_we,
    output logic [21:0] fla_addr,
    output logic [7:0]  fla_dat,
    output logic        erase_req,
    output logic        erase_chip,
    output logic        busy,
    output logic [1:0]  fla_state
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_UNL1,
        S_UNL2,
        S_PROG_ARM,
        S_ERS_ARM,
        S_ERS_UNL1,
        S_ERS_UNL2,
        S_PROG_BUSY,
        S_ERS_BUSY
    } state_t;

    state_t           state;
    state_t           nxt;
    logic [2:0]       m2_sync;
    logic [CNT_W-1:0] cnt;
    logic             wev;
    logic             is_5555;
    logic             is_2aaa;
    logic             in_busy;
    logic             do_prog;
    logic             do_erase;
    logic             chip_sel;

    function automatic logic [1:0] state_code(input state_t s);
        case (s)
            S_IDLE:                  state_code = 2'd0;
            S_PROG_ARM:              state_code = 2'd2;
            S_PROG_BUSY, S_ERS_BUSY: state_code = 2'd3;
            default:                 state_code = 2'd1;
        endcase
    endfunction

    // m2_sync[2] is the previous synchronised sample, used for edge detection
    always_ff @(posedge clk) begin
        if (rst) m2_sync <= 3'b000;
        else     m2_sync <= {m2_sync[1:0], m2};
    end

    assign wev     = m2_sync[2] & ~m2_sync[1] & ~cpu_rw & cpu_addr[15] & fla_en;
    assign is_5555 = (cpu_addr[14:0] == 15'h5555);
    assign is_2aaa = (cpu_addr[14:0] == 15'h2AAA);
    assign in_busy = (state == S_PROG_BUSY) || (state == S_ERS_BUSY);

    // Command decode; every unexpected write during a sequence aborts to IDLE
    always_comb begin
        nxt      = state;
        do_prog  = 1'b0;
        do_erase = 1'b0;
        chip_sel = 1'b0;
        case (state)
            S_IDLE:     if (wev) nxt = (is_5555 && cpu_dat == 8'hAA) ? S_UNL1 : S_IDLE;
            S_UNL1:     if (wev) nxt = (is_2aaa && cpu_dat == 8'h55) ? S_UNL2 : S_IDLE;
            S_UNL2: begin
                if (wev) begin
                    if (is_5555 && cpu_dat == 8'hA0)      nxt = S_PROG_ARM;
                    else if (is_5555 && cpu_dat == 8'h80) nxt = S_ERS_ARM;
                    else                                  nxt = S_IDLE;
                end
            end
            S_PROG_ARM: begin
                if (wev) begin
                    nxt     = S_PROG_BUSY;
                    do_prog = 1'b1;
                end
            end
            S_ERS_ARM:  if (wev) nxt = (is_5555 && cpu_dat == 8'hAA) ? S_ERS_UNL1 : S_IDLE;
            S_ERS_UNL1: if (wev) nxt = (is_2aaa && cpu_dat == 8'h55) ? S_ERS_UNL2 : S_IDLE;
            S_ERS_UNL2: begin
                if (wev) begin
                    if (is_5555 && cpu_dat == 8'h10) begin
                        nxt      = S_ERS_BUSY;
                        do_erase = 1'b1;
                        chip_sel = 1'b1;
                    end else if (cpu_dat == 8'h30) begin
                        nxt      = S_ERS_BUSY;
                        do_erase = 1'b1;
                    end else begin
                        nxt = S_IDLE;
                    end
                end
            end
            S_PROG_BUSY, S_ERS_BUSY: if (cnt == '0) nxt = S_IDLE;
            default:    nxt = S_IDLE;
        endcase
        if (!fla_en && !in_busy) nxt = S_IDLE;
    end

    // State, counter and registered outputs; strobes start on the latching edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            fla_we     <= 1'b0;
            fla_addr   <= '0;
            fla_dat    <= '0;
            erase_req  <= 1'b0;
            erase_chip <= 1'b0;
            busy       <= 1'b0;
            fla_state  <= 2'd0;
        end else begin
            state     <= nxt;
            fla_state <= state_code(nxt);
            busy      <= (nxt == S_PROG_BUSY) || (nxt == S_ERS_BUSY);
            erase_req <= do_erase;
            if (do_prog) begin
                fla_addr <= {prg_bank, cpu_addr[13:0]};
                fla_dat  <= cpu_dat;
                cnt      <= CNT_W'(PROG_CYCLES - 1);
                fla_we   <= 1'b1;
            end else if (do_erase) begin
                if (!chip_sel) fla_addr <= {prg_bank, cpu_addr[13:0]};
                erase_chip <= chip_sel;
                cnt        <= CNT_W'(ERASE_CYCLES - 1);
                fla_we     <= 1'b0;
            end else if (in_busy) begin
                if (cnt != '0) cnt <= cnt - CNT_W'(1);
                // strobe covers the first WE_CYCLES counts of the program window
                fla_we <= (state == S_PROG_BUSY) && (cnt > CNT_W'(PROG_CYCLES - WE_CYCLES));
            end else begin
                fla_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_map_fla_seq.sv
// Bench for map_fla_seq: directed command scenarios plus randomized write streams
// compared against a history-based command model.
module tb_map_fla_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fla_en = 1'b1;
    logic        m2 = 1'b0;
    logic        cpu_rw = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_dat = 8'h00;
    logic [7:0]  prg_bank = 8'h00;
    logic        fla_we;
    logic [21:0] fla_addr;
    logic [7:0]  fla_dat;
    logic        erase_req;
    logic        erase_chip;
    logic        busy;
    logic [1:0]  fla_state;

    int errors = 0;
    int checks = 0;
    int we_tot = 0;
    int er_tot = 0;
    int bz_tot = 0;

    typedef struct {
        logic [14:0] ca;
        logic [7:0]  d;
    } wr_t;

    wr_t hist[$];
    logic [14:0] p_ca [3] = '{15'h5555, 15'h2AAA, 15'h5555};
    logic [7:0]  p_d  [3] = '{8'hAA, 8'h55, 8'hA0};
    logic [14:0] e_ca [5] = '{15'h5555, 15'h2AAA, 15'h5555, 15'h5555, 15'h2AAA};
    logic [7:0]  e_d  [5] = '{8'hAA, 8'h55, 8'h80, 8'hAA, 8'h55};

    map_fla_seq dut (
        .clk(clk), .rst(rst), .fla_en(fla_en), .m2(m2), .cpu_rw(cpu_rw),
        .cpu_addr(cpu_addr), .cpu_dat(cpu_dat), .prg_bank(prg_bank),
        .fla_we(fla_we), .fla_addr(fla_addr), .fla_dat(fla_dat),
        .erase_req(erase_req), .erase_chip(erase_chip), .busy(busy),
        .fla_state(fla_state)
    );

    always #5 clk = ~clk;

    // cycle totals of each strobe, sampled mid-cycle
    always @(negedge clk) begin
        if (fla_we === 1'b1)    we_tot <= we_tot + 1;
        if (erase_req === 1'b1) er_tot <= er_tot + 1;
        if (busy === 1'b1)      bz_tot <= bz_tot + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d, input logic rw);
        cpu_addr = a;
        cpu_dat  = d;
        cpu_rw   = rw;
        m2       = 1'b1;
        tick(3);
        m2 = 1'b0;
        tick(5);
        cpu_rw = 1'b1;
    endtask

    task automatic chk_state(input logic [1:0] exp, input string name);
        checks++;
        if (fla_state !== exp) begin
            errors++;
            $display("FAIL %s fla_state got=%0d exp=%0d", name, fla_state, exp);
        end
    endtask

    task automatic wait_idle(input int bound, input string name);
        int n = 0;
        while (busy === 1'b1 && n < bound) begin
            tick(1);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy still high after %0d cycles", name, bound);
        end
        tick(2);
    endtask

    // History model: a write stream is a command prefix, a complete command, or garbage
    function automatic bit hist_match(input int n, input bit ers);
        for (int i = 0; i < n; i++) begin
            if (ers) begin
                if (hist[i].ca != e_ca[i] || hist[i].d != e_d[i]) return 1'b0;
            end else begin
                if (hist[i].ca != p_ca[i] || hist[i].d != p_d[i]) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    task automatic model_write(input logic [14:0] ca, input logic [7:0] d,
                               output int op, output bit chip, output logic [1:0] st);
        wr_t w;
        int  n;
        bit  pm, em;
        w.ca = ca;
        w.d  = d;
        hist.push_back(w);
        n    = hist.size();
        op   = 0;
        chip = 1'b0;
        pm   = (n <= 4) && hist_match((n > 3) ? 3 : n, 1'b0);
        em   = (n <= 6) && hist_match((n > 5) ? 5 : n, 1'b1);
        if (n == 4 && pm) begin
            op = 1;
        end else if (n == 6 && em && ((ca == 15'h5555 && d == 8'h10) || d == 8'h30)) begin
            op   = 2;
            chip = (ca == 15'h5555 && d == 8'h10);
        end else if (!(n <= 3 && pm) && !(n <= 5 && em)) begin
            hist.delete();
        end
        if (op != 0) hist.delete();
        if (op != 0)                                   st = 2'd3;
        else if (hist.size() == 0)                     st = 2'd0;
        else if (hist.size() == 3 && hist[2].d == 8'hA0) st = 2'd2;
        else                                           st = 2'd1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        checks++;
        if ({fla_we, fla_addr, fla_dat, erase_req, erase_chip, busy, fla_state} !== 36'd0) begin
            errors++;
            $display("FAIL reset outputs got we=%b addr=%h dat=%h er=%b ch=%b busy=%b st=%0d exp all 0",
                     fla_we, fla_addr, fla_dat, erase_req, erase_chip, busy, fla_state);
        end
        rst = 1'b0;
        tick(2);
        chk_state(2'd0, "reset_idle");
    endtask

    task automatic test_program();
        int w0, b0, e0;
        wr(16'hD555, 8'hAA, 1'b0); chk_state(2'd1, "prog_unl1");
        wr(16'hAAAA, 8'h55, 1'b0); chk_state(2'd1, "prog_unl2");
        wr(16'hD555, 8'hA0, 1'b0); chk_state(2'd2, "prog_arm");
        w0 = we_tot; b0 = bz_tot; e0 = er_tot;
        prg_bank = 8'h03;
        wr(16'h9234, 8'h5A, 1'b0);
        chk_state(2'd3, "prog_busy_state");
        checks++;
        if (fla_addr !== 22'h0D234 || fla_dat !== 8'h5A) begin
            errors++;
            $display("FAIL prog_latch got addr=%h dat=%h exp addr=0d234 dat=5a", fla_addr, fla_dat);
        end
        wait_idle(200, "prog_done");
        checks++;
        if (we_tot - w0 != 4) begin
            errors++;
            $display("FAIL prog_we_len got=%0d exp=4", we_tot - w0);
        end
        checks++;
        if (bz_tot - b0 != 64 || er_tot - e0 != 0) begin
            errors++;
            $display("FAIL prog_busy_len got busy=%0d erase=%0d exp busy=64 erase=0",
                     bz_tot - b0, er_tot - e0);
        end
        chk_state(2'd0, "prog_end_idle");
    endtask

    task automatic erase_prefix();
        wr(16'hD555, 8'hAA, 1'b0);
        wr(16'hAAAA, 8'h55, 1'b0);
        wr(16'hD555, 8'h80, 1'b0);
        chk_state(2'd1, "ers_arm");
        wr(16'hD555, 8'hAA, 1'b0);
        wr(16'hAAAA, 8'h55, 1'b0);
        chk_state(2'd1, "ers_unl2");
    endtask

    task automatic test_erase(input bit chip);
        int w0, b0, e0;
        erase_prefix();
        w0 = we_tot; b0 = bz_tot; e0 = er_tot;
        prg_bank = 8'h01;
        if (chip) wr(16'hD555, 8'h10, 1'b0);
        else      wr(16'hA000, 8'h30, 1'b0);
        chk_state(2'd3, chip ? "chip_state" : "sect_state");
        checks++;
        if (erase_chip !== chip || fla_addr !== 22'h06000) begin
            errors++;
            $display("FAIL %s got chip=%b addr=%h exp chip=%b addr=006000",
                     chip ? "chip_qual" : "sect_qual", erase_chip, fla_addr, chip);
        end
        wait_idle(5000, chip ? "chip_done" : "sect_done");
        checks++;
        if (er_tot - e0 != 1 || bz_tot - b0 != 4096 || we_tot - w0 != 0) begin
            errors++;
            $display("FAIL %s got req=%0d busy=%0d we=%0d exp req=1 busy=4096 we=0",
                     chip ? "chip_len" : "sect_len", er_tot - e0, bz_tot - b0, we_tot - w0);
        end
        chk_state(2'd0, chip ? "chip_idle" : "sect_idle");
    endtask

    task automatic test_broken();
        wr(16'hD555, 8'hAA, 1'b0); chk_state(2'd1, "brk_unl1");
        wr(16'hAAAA, 8'h54, 1'b0); chk_state(2'd0, "brk_bad55");
        wr(16'hAAAA, 8'h55, 1'b0); chk_state(2'd0, "brk_no_resume");
        wr(16'hD555, 8'hAA, 1'b0);
        wr(16'hAAAA, 8'h55, 1'b0);
        wr(16'hD555, 8'hAA, 1'b0); chk_state(2'd0, "brk_aa_restart");
        wr(16'hD555, 8'hAA, 1'b0);
        wr(16'hD555, 8'hF0, 1'b0); chk_state(2'd0, "brk_f0");
    endtask

    task automatic test_busy_lockout();
        int b0;
        wr(16'hD555, 8'hAA, 1'b0);
        wr(16'hAAAA, 8'h55, 1'b0);
        wr(16'hD555, 8'hA0, 1'b0);
        b0 = bz_tot;
        prg_bank = 8'h2C;
        wr(16'hC001, 8'h77, 1'b0);
        wr(16'hD555, 8'hF0, 1'b0); chk_state(2'd3, "lock_f0");
        wr(16'hD555, 8'hAA, 1'b0); chk_state(2'd3, "lock_aa");
        wait_idle(200, "lock_done");
        checks++;
        if (bz_tot - b0 != 64 || fla_addr !== 22'h0B0001 || fla_dat !== 8'h77) begin
            errors++;
            $display("FAIL lock_len got busy=%0d addr=%h dat=%h exp busy=64 addr=0b0001 dat=77",
                     bz_tot - b0, fla_addr, fla_dat);
        end
        chk_state(2'd0, "lock_idle");
    endtask

    task automatic test_reset_mid();
        int n = 0;
        wr(16'hD555, 8'hAA, 1'b0);
        wr(16'hAAAA, 8'h55, 1'b0);
        wr(16'hD555, 8'hA0, 1'b0);
        cpu_addr = 16'h8123; cpu_dat = 8'h99; cpu_rw = 1'b0; m2 = 1'b1;
        tick(3);
        m2 = 1'b0;
        while (fla_we !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        tick(1);
        rst = 1'b1;
        tick(1);
        checks++;
        if (fla_we !== 1'b0 || busy !== 1'b0 || fla_state !== 2'd0 || fla_addr !== 22'd0) begin
            errors++;
            $display("FAIL rst_mid got we=%b busy=%b st=%0d addr=%h exp 0 0 0 0",
                     fla_we, busy, fla_state, fla_addr);
        end
        rst = 1'b0;
        cpu_rw = 1'b1;
        tick(3);
        wr(16'h5555, 8'hAA, 1'b1); chk_state(2'd0, "read_5555");
        wr(16'hD555, 8'hAA, 1'b1); chk_state(2'd0, "read_d555");
        wr(16'h5555, 8'hAA, 1'b0); chk_state(2'd0, "low_write");
    endtask

    task automatic test_fla_en();
        wr(16'hD555, 8'hAA, 1'b0); chk_state(2'd1, "en_unl1");
        fla_en = 1'b0;
        tick(1);
        chk_state(2'd0, "en_drop_idle");
        wr(16'hD555, 8'hAA, 1'b0); chk_state(2'd0, "en_ignored");
        fla_en = 1'b1;
        tick(2);
    endtask

    task automatic test_random();
        logic [21:0] exp_addr = fla_addr;
        logic [7:0]  exp_dat = fla_dat;
        bit          exp_chip = erase_chip;
        bit          path = 1'b0;
        int          erases = 0;
        hist.delete();
        for (int it = 0; it < 120; it++) begin
            logic [14:0] ca;
            logic [7:0]  d;
            logic [1:0]  st;
            int          k, r, op;
            bit          chip;
            k = hist.size();
            if (k == 0) path = (erases < 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (!path) begin
                if (k < 3) begin ca = p_ca[k]; d = p_d[k]; end
                else begin ca = 15'($urandom); d = 8'($urandom); end
            end else begin
                if (k < 5) begin ca = e_ca[k]; d = e_d[k]; end
                else if ($urandom_range(0, 1) == 0) begin ca = 15'h5555; d = 8'h10; end
                else begin ca = 15'($urandom); d = 8'h30; end
            end
            r = $urandom_range(0, 99);
            prg_bank = 8'($urandom);
            if (r < 60) begin
                wr({1'b1, ca}, d, 1'b0);
            end else if (r < 70) begin
                wr({1'b1, ca}, d, 1'b1);
                continue_check(2'($unsigned(model_state())), "rnd_read");
                continue;
            end else if (r < 78) begin
                wr({1'b0, ca}, d, 1'b0);
                continue_check(2'($unsigned(model_state())), "rnd_low");
                continue;
            end else if (r < 86) begin
                ca = 15'h5555; d = 8'hF0;
                wr({1'b1, ca}, d, 1'b0);
            end else begin
                ca = 15'($urandom); d = 8'($urandom);
                wr({1'b1, ca}, d, 1'b0);
            end
            model_write(ca, d, op, chip, st);
            if (op == 1) begin
                exp_addr = {prg_bank, ca[13:0]};
                exp_dat  = d;
            end else if (op == 2) begin
                if (!chip) exp_addr = {prg_bank, ca[13:0]};
                exp_chip = chip;
                erases++;
            end
            chk_state(st, "rnd_state");
            if (op != 0) begin
                checks++;
                if (fla_addr !== exp_addr || fla_dat !== exp_dat || erase_chip !== exp_chip) begin
                    errors++;
                    $display("FAIL rnd_latch got addr=%h dat=%h chip=%b exp addr=%h dat=%h chip=%b",
                             fla_addr, fla_dat, erase_chip, exp_addr, exp_dat, exp_chip);
                end
                wait_idle(5000, "rnd_done");
                chk_state(2'd0, "rnd_idle");
            end
        end
    endtask

    function automatic int model_state();
        if (hist.size() == 0) return 0;
        if (hist.size() == 3 && hist[2].d == 8'hA0) return 2;
        return 1;
    endfunction

    task automatic continue_check(input logic [1:0] exp, input string name);
        chk_state(exp, name);
    endtask

    initial begin
        test_reset();
        test_program();
        test_erase(1'b0);
        test_erase(1'b1);
        test_broken();
        test_busy_lockout();
        test_reset_mid();
        test_fla_en();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
